// File: rtl/imem_assoc.sv
// N-way set-associative instruction cache with round-robin replacement and flush.
// Flop-based arrays read combinationally; one outstanding line fill on the bus.
module imem_assoc #(
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_BITS-1:0]             pc,
    output logic [31:0]                      ir,
    input  logic                             stall,
    output logic                             stall_imem,
    input  logic                             flush,
    output logic [ADDR_BITS-$clog2(LINE_BITS/8)-1:0] b_addr_i,
    input  logic [LINE_BITS-1:0]             b_data_i,
    output logic                             b_rd_i,
    input  logic                             b_dv_i
);
    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_BITS - IDX - OFF;
    localparam int PW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_BITS-OFF-1:0] r_addr;
    logic                     r_pend;
    logic [SETS-1:0][PW-1:0]  r_ptr;

    logic [IDX-1:0]           w_idx;
    logic [TAG-1:0]           w_tag;
    logic [OFF-3:0]           w_wsel;
    logic [IDX-1:0]           w_fidx;
    logic [TAG-1:0]           w_ftag;
    logic [PW-1:0]            w_vic;
    logic [PW-1:0]            w_vic_nxt;
    logic                     w_fill;
    logic                     w_clr;
    logic                     w_hit;
    logic [WAYS-1:0]          w_hit_v;
    logic [WAYS-1:0][31:0]    w_wv;
    logic [31:0]              w_word;
    logic                     w_unused;

    assign w_idx  = pc[OFF+IDX-1:OFF];
    assign w_tag  = pc[ADDR_BITS-1:OFF+IDX];
    assign w_wsel = pc[OFF-1:2];
    assign w_fidx = r_addr[IDX-1:0];
    assign w_ftag = r_addr[ADDR_BITS-OFF-1:IDX];
    assign w_vic  = r_ptr[w_fidx];
    assign w_vic_nxt = (WAYS == 1) ? '0 : w_vic + PW'(1);
    assign w_fill = (r_state == S_FILL) && b_dv_i;
    assign w_clr  = (r_state == S_FLUSH);
    assign w_unused = ^{stall, pc[1:0]};

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [SETS-1:0]      r_valid;
        logic [TAG-1:0]       r_tag  [SETS];
        logic [LINE_BITS-1:0] r_data [SETS];
        logic                 w_we;
        logic [LINE_BITS-1:0] w_line;

        assign w_we   = w_fill && (w_vic == PW'(g));
        assign w_line = r_data[w_idx];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= '0;
            end else if (w_clr) begin
                r_valid <= '0;
            end else if (w_we) begin
                r_valid[w_fidx] <= 1'b1;
            end
        end

        // Payload arrays carry no reset; the valid bits guard them.
        always_ff @(posedge clk) begin
            if (w_we) begin
                r_tag[w_fidx]  <= w_ftag;
                r_data[w_fidx] <= b_data_i;
            end
        end

        assign w_hit_v[g] = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        assign w_wv[g]    = w_hit_v[g] ? w_line[{w_wsel, 5'b0} +: 32] : '0;
    end

    always_comb begin
        w_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_word = w_word | w_wv[PW'(w)];
        end
    end

    assign w_hit      = |w_hit_v;
    assign ir         = w_hit ? w_word : NOP;
    assign stall_imem = (r_state != S_IDLE) || !w_hit;
    assign b_rd_i     = (r_state == S_FILL);
    assign b_addr_i   = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else if (!w_hit) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (b_dv_i) begin
                    w_state_nxt = (r_pend || flush) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (r_state == S_IDLE && !flush && !w_hit) begin
            r_addr <= pc[ADDR_BITS-1:OFF];
        end
    end

    // A flush arriving mid-fill is remembered and run once the line lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (r_state == S_FLUSH) begin
            r_pend <= 1'b0;
        end else if (r_state == S_FILL && flush) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_clr) begin
            r_ptr <= '0;
        end else if (w_fill) begin
            r_ptr[w_fidx] <= w_vic_nxt;
        end
    end

endmodule
